// File: rtl/mem_load_forward_ctrl.sv
// MEM-stage load/store sequencer: drives the dcache handshake, stalls the pipe while an
// access is outstanding and publishes a one-cycle load forwarding beat to the EX hazard unit.
module mem_load_forward_ctrl #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ADDR_WIDTH    = 64,
  parameter int unsigned RF_ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     EXMem_Valid,
  input  logic                     EXMem_LdEN,
  input  logic                     EXMem_StEN,
  input  logic [2:0]               EXMem_Funct3,
  input  logic [RF_ADDR_WIDTH-1:0] EXMem_RdAddr,
  input  logic [ADDR_WIDTH-1:0]    EXMem_AluData,
  input  logic [DATA_WIDTH-1:0]    EXMem_StData,
  output logic                     Dcache_Req,
  output logic                     Dcache_Wr,
  output logic [ADDR_WIDTH-1:0]    Dcache_Addr,
  output logic [DATA_WIDTH-1:0]    Dcache_WrData,
  output logic [7:0]               Dcache_ByteEn,
  input  logic                     Dcache_Ack,
  input  logic [DATA_WIDTH-1:0]    Dcache_RdData,
  input  logic                     Dcache_Err,
  output logic                     Mem_Stall,
  output logic                     Mem_LdEN,
  output logic [RF_ADDR_WIDTH-1:0] Mem_RdAddr,
  output logic [DATA_WIDTH-1:0]    Mem_LdData,
  output logic                     Mem_Exception
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [2:0]               funct3_q;
  logic [RF_ADDR_WIDTH-1:0] rd_q;
  logic                     wr_q;
  logic [DATA_WIDTH-1:0]    wrdata_q;
  logic [7:0]               byteen_q;
  logic [DATA_WIDTH-1:0]    ld_data_q;
  logic [RF_ADDR_WIDTH-1:0] ld_rd_q;
  logic                     exc_q, exc_d;
  logic                     ld_capture;

  logic [1:0]            size_in;
  logic                  addr_misalign;
  logic                  op_valid;
  logic                  misaligned;
  logic                  accept;
  logic [7:0]            be_base;
  logic [DATA_WIDTH-1:0] st_shift;
  logic [DATA_WIDTH-1:0] rd_shift;
  logic [DATA_WIDTH-1:0] ld_ext;

  // Size code: 0=byte 1=half 2=word 3=double; SIMD (111) is a 64-bit access.
  always_comb begin
    size_in = (EXMem_Funct3 == 3'b111) ? 2'd3 : EXMem_Funct3[1:0];
    unique case (size_in)
      2'd0:    begin addr_misalign = 1'b0;                  be_base = 8'h01; end
      2'd1:    begin addr_misalign = EXMem_AluData[0];      be_base = 8'h03; end
      2'd2:    begin addr_misalign = |EXMem_AluData[1:0];   be_base = 8'h0F; end
      default: begin addr_misalign = |EXMem_AluData[2:0];   be_base = 8'hFF; end
    endcase
  end

  // A load+store combination is illegal and reported like a misalignment.
  assign op_valid   = EXMem_Valid & (EXMem_LdEN | EXMem_StEN);
  assign misaligned = (EXMem_LdEN & EXMem_StEN) | addr_misalign;
  assign accept     = (state_q == StIdle) & op_valid & ~misaligned;
  assign st_shift   = EXMem_StData << {EXMem_AluData[2:0], 3'b000};

  assign rd_shift = Dcache_RdData >> {addr_q[2:0], 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  ld_ext = {{(DATA_WIDTH-8){rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_ext = {{(DATA_WIDTH-16){rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  ld_ext = {{(DATA_WIDTH-32){rd_shift[31]}}, rd_shift[31:0]};
      3'b100:  ld_ext = {{(DATA_WIDTH-8){1'b0}}, rd_shift[7:0]};
      3'b101:  ld_ext = {{(DATA_WIDTH-16){1'b0}}, rd_shift[15:0]};
      3'b110:  ld_ext = {{(DATA_WIDTH-32){1'b0}}, rd_shift[31:0]};
      default: ld_ext = rd_shift;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    exc_d      = 1'b0;
    ld_capture = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StReq;
        end else if (op_valid) begin
          exc_d = 1'b1;
        end
      end
      StReq: begin
        if (Dcache_Ack) begin
          if (Dcache_Err) begin
            exc_d   = 1'b1;
            state_d = StIdle;
          end else if (!wr_q) begin
            ld_capture = 1'b1;
            state_d    = StDone;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      funct3_q  <= '0;
      rd_q      <= '0;
      wr_q      <= 1'b0;
      wrdata_q  <= '0;
      byteen_q  <= '0;
      ld_data_q <= '0;
      ld_rd_q   <= '0;
      exc_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      exc_q   <= exc_d;
      if (accept) begin
        addr_q   <= EXMem_AluData;
        funct3_q <= EXMem_Funct3;
        rd_q     <= EXMem_RdAddr;
        wr_q     <= EXMem_StEN;
        wrdata_q <= st_shift;
        byteen_q <= EXMem_StEN ? (be_base << EXMem_AluData[2:0]) : 8'h00;
      end
      if (ld_capture) begin
        ld_data_q <= ld_ext;
        ld_rd_q   <= rd_q;
      end
    end
  end

  assign Dcache_Req    = (state_q == StReq);
  assign Dcache_Wr     = Dcache_Req & wr_q;
  assign Dcache_Addr   = {addr_q[ADDR_WIDTH-1:3], 3'b000};
  assign Dcache_WrData = wrdata_q;
  assign Dcache_ByteEn = Dcache_Req ? byteen_q : 8'h00;
  assign Mem_Stall     = accept | (state_q == StReq);
  assign Mem_LdEN      = (state_q == StDone) & (|rd_q);
  assign Mem_RdAddr    = ld_rd_q;
  assign Mem_LdData    = ld_data_q;
  assign Mem_Exception = exc_q;

endmodule

// File: tb/tb_mem_load_forward_ctrl.sv
// Directed bench for mem_load_forward_ctrl: loads, stores, misalignment, bus error and
// asynchronous reset during an outstanding request.
module tb_mem_load_forward_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        EXMem_Valid, EXMem_LdEN, EXMem_StEN;
  logic [2:0]  EXMem_Funct3;
  logic [4:0]  EXMem_RdAddr;
  logic [63:0] EXMem_AluData, EXMem_StData;
  logic        Dcache_Req, Dcache_Wr;
  logic [63:0] Dcache_Addr, Dcache_WrData;
  logic [7:0]  Dcache_ByteEn;
  logic        Dcache_Ack, Dcache_Err;
  logic [63:0] Dcache_RdData;
  logic        Mem_Stall, Mem_LdEN, Mem_Exception;
  logic [4:0]  Mem_RdAddr;
  logic [63:0] Mem_LdData;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_load_forward_ctrl #(
    .DATA_WIDTH(64),
    .ADDR_WIDTH(64),
    .RF_ADDR_WIDTH(5)
  ) dut (
    .clk(clk), .rst(rst),
    .EXMem_Valid(EXMem_Valid), .EXMem_LdEN(EXMem_LdEN), .EXMem_StEN(EXMem_StEN),
    .EXMem_Funct3(EXMem_Funct3), .EXMem_RdAddr(EXMem_RdAddr),
    .EXMem_AluData(EXMem_AluData), .EXMem_StData(EXMem_StData),
    .Dcache_Req(Dcache_Req), .Dcache_Wr(Dcache_Wr), .Dcache_Addr(Dcache_Addr),
    .Dcache_WrData(Dcache_WrData), .Dcache_ByteEn(Dcache_ByteEn),
    .Dcache_Ack(Dcache_Ack), .Dcache_RdData(Dcache_RdData), .Dcache_Err(Dcache_Err),
    .Mem_Stall(Mem_Stall), .Mem_LdEN(Mem_LdEN), .Mem_RdAddr(Mem_RdAddr),
    .Mem_LdData(Mem_LdData), .Mem_Exception(Mem_Exception)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [63:0] addr, input logic [63:0] sd);
    EXMem_Valid = 1'b1; EXMem_LdEN = ld; EXMem_StEN = st; EXMem_Funct3 = f3;
    EXMem_RdAddr = rd; EXMem_AluData = addr; EXMem_StData = sd;
    #1;
  endtask

  task automatic idle_inputs();
    EXMem_Valid = 1'b0; EXMem_LdEN = 1'b0; EXMem_StEN = 1'b0;
    Dcache_Ack = 1'b0; Dcache_Err = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    EXMem_Funct3 = 3'b000; EXMem_RdAddr = '0; EXMem_AluData = '0; EXMem_StData = '0;
    Dcache_RdData = '0;
    rst = 1'b1;
    tick(); tick();
    vectors++; if ({Dcache_Req, Dcache_Wr, Mem_Stall, Mem_LdEN, Mem_Exception} !== 5'b0) begin
      miscompares++; $display("FAIL reset_ctrl got %b exp 00000",
        {Dcache_Req, Dcache_Wr, Mem_Stall, Mem_LdEN, Mem_Exception}); end
    vectors++; if ({Dcache_Addr, Dcache_WrData, Dcache_ByteEn, Mem_RdAddr, Mem_LdData} !== '0)
      begin miscompares++; $display("FAIL reset_data got addr %h ld %h exp 0",
        Dcache_Addr, Mem_LdData); end
    #2 rst = 1'b0;
  endtask

  task automatic test_lb();
    tick();
    present(1'b1, 1'b0, 3'b000, 5'd5, 64'h1003, '0);
    vectors++; if (Mem_Stall !== 1'b1 || Dcache_Req !== 1'b0) begin miscompares++;
      $display("FAIL lb_accept stall %b req %b exp 1 0", Mem_Stall, Dcache_Req); end
    tick();
    idle_inputs();
    Dcache_Ack = 1'b1; Dcache_RdData = 64'h00000000_80000000; #1;
    vectors++; if (Dcache_Req !== 1'b1 || Dcache_Addr !== 64'h1000 || Mem_Stall !== 1'b1
      || Dcache_Wr !== 1'b0) begin miscompares++;
      $display("FAIL lb_req req %b addr %h stall %b wr %b exp 1 1000 1 0",
        Dcache_Req, Dcache_Addr, Mem_Stall, Dcache_Wr); end
    tick();
    Dcache_Ack = 1'b0; #1;
    vectors++; if (Mem_LdEN !== 1'b1 || Mem_RdAddr !== 5'd5 || Mem_Stall !== 1'b0) begin
      miscompares++; $display("FAIL lb_beat lden %b rd %0d stall %b exp 1 5 0",
        Mem_LdEN, Mem_RdAddr, Mem_Stall); end
    vectors++; if (Mem_LdData !== 64'hFFFFFFFF_FFFFFF80) begin miscompares++;
      $display("FAIL lb_data got %h exp ffffffffffffff80", Mem_LdData); end
    tick();
    vectors++; if (Mem_LdEN !== 1'b0 || Mem_LdData !== 64'hFFFFFFFF_FFFFFF80) begin
      miscompares++; $display("FAIL lb_hold lden %b data %h exp 0 ffffffffffffff80",
        Mem_LdEN, Mem_LdData); end
  endtask

  task automatic test_lwu_delayed();
    present(1'b1, 1'b0, 3'b110, 5'd7, 64'h2004, '0);
    tick();
    idle_inputs();
    Dcache_RdData = 64'h89ABCDEF_01234567;
    for (int i = 0; i < 4; i++) begin
      Dcache_Ack = (i == 3); #1;
      vectors++; if (Dcache_Req !== 1'b1 || Dcache_Addr !== 64'h2000 || Mem_Stall !== 1'b1)
        begin miscompares++; $display("FAIL lwu_req%0d req %b addr %h stall %b exp 1 2000 1",
          i, Dcache_Req, Dcache_Addr, Mem_Stall); end
      tick();
    end
    Dcache_Ack = 1'b0; #1;
    vectors++; if (Mem_LdEN !== 1'b1 || Mem_RdAddr !== 5'd7
      || Mem_LdData !== 64'h00000000_89ABCDEF) begin miscompares++;
      $display("FAIL lwu_beat lden %b rd %0d data %h exp 1 7 0000000089abcdef",
        Mem_LdEN, Mem_RdAddr, Mem_LdData); end
    tick();
  endtask

  task automatic test_sh();
    present(1'b0, 1'b1, 3'b001, 5'd9, 64'h3006, 64'h0000_0000_0000_BEEF);
    tick();
    idle_inputs();
    Dcache_Ack = 1'b1; #1;
    vectors++; if (Dcache_Req !== 1'b1 || Dcache_Wr !== 1'b1 || Dcache_ByteEn !== 8'hC0
      || Dcache_Addr !== 64'h3000) begin miscompares++;
      $display("FAIL sh_req req %b wr %b be %h addr %h exp 1 1 c0 3000",
        Dcache_Req, Dcache_Wr, Dcache_ByteEn, Dcache_Addr); end
    vectors++; if (Dcache_WrData !== 64'hBEEF0000_00000000) begin miscompares++;
      $display("FAIL sh_wrdata got %h exp beef000000000000", Dcache_WrData); end
    tick();
    Dcache_Ack = 1'b0; #1;
    vectors++; if (Mem_LdEN !== 1'b0 || Dcache_Req !== 1'b0 || Mem_Stall !== 1'b0) begin
      miscompares++; $display("FAIL sh_after lden %b req %b stall %b exp 0 0 0",
        Mem_LdEN, Dcache_Req, Mem_Stall); end
  endtask

  task automatic test_misalign();
    present(1'b1, 1'b0, 3'b010, 5'd4, 64'h4002, '0);
    vectors++; if (Mem_Stall !== 1'b0) begin miscompares++;
      $display("FAIL mis_stall got %b exp 0", Mem_Stall); end
    tick();
    idle_inputs(); #1;
    vectors++; if (Mem_Exception !== 1'b1 || Dcache_Req !== 1'b0 || Mem_LdEN !== 1'b0) begin
      miscompares++; $display("FAIL mis_exc exc %b req %b lden %b exp 1 0 0",
        Mem_Exception, Dcache_Req, Mem_LdEN); end
    tick();
    vectors++; if (Mem_Exception !== 1'b0 || Dcache_Req !== 1'b0) begin miscompares++;
      $display("FAIL mis_pulse exc %b req %b exp 0 0", Mem_Exception, Dcache_Req); end
    present(1'b1, 1'b0, 3'b011, 5'd3, 64'h5008, '0);
    tick();
    idle_inputs();
    Dcache_Ack = 1'b1; Dcache_RdData = 64'h11223344_55667788; #1;
    vectors++; if (Dcache_Req !== 1'b1 || Dcache_Addr !== 64'h5008) begin miscompares++;
      $display("FAIL mis_next_req req %b addr %h exp 1 5008", Dcache_Req, Dcache_Addr); end
    tick();
    Dcache_Ack = 1'b0; #1;
    vectors++; if (Mem_LdEN !== 1'b1 || Mem_RdAddr !== 5'd3
      || Mem_LdData !== 64'h11223344_55667788) begin miscompares++;
      $display("FAIL mis_next_beat lden %b rd %0d data %h exp 1 3 1122334455667788",
        Mem_LdEN, Mem_RdAddr, Mem_LdData); end
    tick();
  endtask

  task automatic test_simd_rd0();
    present(1'b1, 1'b0, 3'b111, 5'd0, 64'h6000, '0);
    tick();
    idle_inputs();
    Dcache_Ack = 1'b1; Dcache_Err = 1'b1; Dcache_RdData = 64'h0123_4567_89AB_CDEF; #1;
    tick();
    Dcache_Ack = 1'b0; Dcache_Err = 1'b0; #1;
    vectors++; if (Mem_Exception !== 1'b1 || Mem_LdEN !== 1'b0 || Dcache_Req !== 1'b0) begin
      miscompares++; $display("FAIL simd_err exc %b lden %b req %b exp 1 0 0",
        Mem_Exception, Mem_LdEN, Dcache_Req); end
    vectors++; if (Mem_LdData !== 64'h11223344_55667788) begin miscompares++;
      $display("FAIL simd_err_hold got %h exp 1122334455667788", Mem_LdData); end
    tick();
    vectors++; if (Mem_Exception !== 1'b0) begin miscompares++;
      $display("FAIL simd_err_pulse got %b exp 0", Mem_Exception); end
    present(1'b1, 1'b0, 3'b111, 5'd0, 64'h6000, '0);
    tick();
    idle_inputs();
    Dcache_Ack = 1'b1; Dcache_RdData = 64'hCAFEBABE_DEADBEEF; #1;
    tick();
    Dcache_Ack = 1'b0; #1;
    vectors++; if (Mem_LdEN !== 1'b0 || Mem_Exception !== 1'b0
      || Mem_LdData !== 64'hCAFEBABE_DEADBEEF) begin miscompares++;
      $display("FAIL simd_rd0 lden %b exc %b data %h exp 0 0 cafebabedeadbeef",
        Mem_LdEN, Mem_Exception, Mem_LdData); end
    tick();
  endtask

  task automatic test_reset_mid();
    present(1'b1, 1'b0, 3'b000, 5'd9, 64'h7000, '0);
    tick();
    idle_inputs(); #1;
    vectors++; if (Dcache_Req !== 1'b1) begin miscompares++;
      $display("FAIL rstmid_req got %b exp 1", Dcache_Req); end
    rst = 1'b1; #1;
    vectors++; if (Dcache_Req !== 1'b0 || Mem_Stall !== 1'b0) begin miscompares++;
      $display("FAIL rstmid_async req %b stall %b exp 0 0", Dcache_Req, Mem_Stall); end
    tick();
    rst = 1'b0;
    Dcache_Ack = 1'b1; Dcache_RdData = 64'hFFFF_FFFF_FFFF_FFFF; #1;
    tick();
    Dcache_Ack = 1'b0; #1;
    vectors++; if (Dcache_Req !== 1'b0 || Mem_LdEN !== 1'b0 || Mem_Exception !== 1'b0
      || Mem_LdData !== 64'h0) begin miscompares++;
      $display("FAIL rstmid_ack req %b lden %b exc %b data %h exp 0 0 0 0",
        Dcache_Req, Mem_LdEN, Mem_Exception, Mem_LdData); end
    tick();
    vectors++; if (Mem_LdEN !== 1'b0 || Dcache_Req !== 1'b0) begin miscompares++;
      $display("FAIL rstmid_quiet lden %b req %b exp 0 0", Mem_LdEN, Dcache_Req); end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_lwu_delayed();
    test_sh();
    test_misalign();
    test_simd_rd0();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
